// File: rtl/loader_pkg.sv
// loader_pkg: shared states, target codes and default widths for the program loader
package loader_pkg;
  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, READ, CHECK, SETTLE, RUN} state_t;
  localparam logic TGT_INST = 1'b0;
  localparam logic TGT_DATA = 1'b1;
  localparam int DEF_INST_W = 32;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_INST_AW = 7;
  localparam int DEF_DATA_AW = 11;
  localparam int DEF_ERR_W = 8;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: host stream, memory export and CPU control bundle of the loader
interface program_loader_if import loader_pkg::*; #(
  parameter int INST_W = DEF_INST_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int INST_AW = DEF_INST_AW,
  parameter int DATA_AW = DEF_DATA_AW,
  parameter int ERR_W = DEF_ERR_W
);
  logic start, verify_en, in_valid, in_ready, in_target, in_last;
  logic [INST_W-1:0] in_data;
  logic cpu_rst, cpu_enPC;
  logic [INST_AW-1:0] inst_addr;
  logic [INST_W-1:0] inst_wdata, inst_rdata;
  logic inst_MW, inst_MR;
  logic [DATA_AW-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata, data_rdata;
  logic data_MW, data_MR;
  logic busy, done, err_overflow;
  logic [ERR_W-1:0] err_count;
  modport master (
    input start, verify_en, in_valid, in_target, in_data, in_last, inst_rdata, data_rdata,
    output in_ready, cpu_rst, cpu_enPC, inst_addr, inst_wdata, inst_MW, inst_MR,
    output data_addr, data_wdata, data_MW, data_MR, busy, done, err_overflow, err_count
  );
  modport slave (
    output start, verify_en, in_valid, in_target, in_data, in_last, inst_rdata, data_rdata,
    input in_ready, cpu_rst, cpu_enPC, inst_addr, inst_wdata, inst_MW, inst_MR,
    input data_addr, data_wdata, data_MW, data_MR, busy, done, err_overflow, err_count
  );
endinterface

// File: rtl/loader_addr_ctr.sv
// loader_addr_ctr: (AW+1)-bit address counter; top bit flags overflow and freezes the count
module loader_addr_ctr #(
  parameter int AW = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [AW:0] cnt_o,
  output logic        ovf_o
);
  logic [AW:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (inc_i && !cnt_q[AW]) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
  assign ovf_o = cnt_q[AW];
endmodule

// File: rtl/program_loader.sv
// program_loader: streams host words into CPU instruction/data memory with optional
// readback, holding the CPU in reset until the image is loaded.
module program_loader import loader_pkg::*; #(
  parameter int INST_W = DEF_INST_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int INST_AW = DEF_INST_AW,
  parameter int DATA_AW = DEF_DATA_AW,
  parameter int RD_LAT = 1,
  parameter int SETTLE_CYC = 4,
  parameter int ERR_W = DEF_ERR_W
) (
  input logic clk,
  input logic rst,
  program_loader_if.master bus
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYC - 1);
  state_t state_q;
  logic verify_q, tgt_q, last_q, ovf_q;
  logic [INST_W-1:0] word_q, inst_wdata_q;
  logic [1:0] rd_cnt_q;
  logic [SW-1:0] set_cnt_q;
  logic [INST_AW-1:0] inst_addr_q;
  logic [DATA_AW-1:0] data_addr_q;
  logic [DATA_W-1:0] data_wdata_q;
  logic inst_mw_q, inst_mr_q, data_mw_q, data_mr_q;
  logic in_ready_q, cpu_rst_q, enpc_q, busy_q, done_q, err_ovf_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [INST_AW:0] inst_cnt;
  logic [DATA_AW:0] data_cnt;
  logic inst_ovf, data_ovf, clr, mismatch;
  assign clr = bus.start && (state_q == IDLE || state_q == RUN);
  assign mismatch = tgt_q ? (bus.data_rdata != word_q[DATA_W-1:0]) : (bus.inst_rdata != word_q);
  loader_addr_ctr #(.AW(INST_AW)) u_inst_ctr (
    .clk(clk), .rst(rst), .clr_i(clr), .inc_i(state_q == WRITE && tgt_q == TGT_INST),
    .cnt_o(inst_cnt), .ovf_o(inst_ovf)
  );
  loader_addr_ctr #(.AW(DATA_AW)) u_data_ctr (
    .clk(clk), .rst(rst), .clr_i(clr), .inc_i(state_q == WRITE && tgt_q == TGT_DATA),
    .cnt_o(data_cnt), .ovf_o(data_ovf)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      {verify_q, tgt_q, last_q, ovf_q} <= '0;
      word_q <= '0;
      inst_wdata_q <= '0;
      data_wdata_q <= '0;
      inst_addr_q <= '0;
      data_addr_q <= '0;
      rd_cnt_q <= '0;
      set_cnt_q <= '0;
      {inst_mw_q, inst_mr_q, data_mw_q, data_mr_q} <= '0;
      {in_ready_q, enpc_q, busy_q, done_q, err_ovf_q} <= '0;
      cpu_rst_q <= 1'b1;
      err_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE, RUN: if (bus.start) begin
          verify_q <= bus.verify_en;
          err_cnt_q <= '0;
          err_ovf_q <= 1'b0;
          done_q <= 1'b0;
          cpu_rst_q <= 1'b1;
          enpc_q <= 1'b0;
          busy_q <= 1'b1;
          in_ready_q <= 1'b1;
          state_q <= ACCEPT;
        end
        ACCEPT: if (bus.in_valid) begin
          tgt_q <= bus.in_target;
          word_q <= bus.in_data;
          last_q <= bus.in_last;
          in_ready_q <= 1'b0;
          state_q <= WRITE;
          if (bus.in_target == TGT_DATA) begin
            data_addr_q <= data_cnt[DATA_AW-1:0];
            data_wdata_q <= bus.in_data[DATA_W-1:0];
            data_mw_q <= !data_ovf;
            ovf_q <= data_ovf;
          end else begin
            inst_addr_q <= inst_cnt[INST_AW-1:0];
            inst_wdata_q <= bus.in_data;
            inst_mw_q <= !inst_ovf;
            ovf_q <= inst_ovf;
          end
        end
        WRITE: begin
          inst_mw_q <= 1'b0;
          data_mw_q <= 1'b0;
          if (ovf_q) err_ovf_q <= 1'b1;
          // overflowed words were never written, so there is nothing to read back
          if (verify_q && !ovf_q) begin
            state_q <= READ;
            rd_cnt_q <= '0;
            inst_mr_q <= tgt_q == TGT_INST;
            data_mr_q <= tgt_q == TGT_DATA;
          end else begin
            state_q <= last_q ? SETTLE : ACCEPT;
            cpu_rst_q <= !last_q;
            in_ready_q <= !last_q;
            set_cnt_q <= '0;
          end
        end
        READ: if (rd_cnt_q == RD_LAST) begin
          inst_mr_q <= 1'b0;
          data_mr_q <= 1'b0;
          state_q <= CHECK;
        end else rd_cnt_q <= rd_cnt_q + 1'b1;
        CHECK: begin
          if (mismatch && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
          state_q <= last_q ? SETTLE : ACCEPT;
          cpu_rst_q <= !last_q;
          in_ready_q <= !last_q;
          set_cnt_q <= '0;
        end
        SETTLE: if (set_cnt_q == S_LAST) begin
          enpc_q <= 1'b1;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state_q <= RUN;
        end else set_cnt_q <= set_cnt_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.cpu_rst = cpu_rst_q;
  assign bus.cpu_enPC = enpc_q;
  assign bus.inst_addr = inst_addr_q;
  assign bus.inst_wdata = inst_wdata_q;
  assign bus.inst_MW = inst_mw_q;
  assign bus.inst_MR = inst_mr_q;
  assign bus.data_addr = data_addr_q;
  assign bus.data_wdata = data_wdata_q;
  assign bus.data_MW = data_mw_q;
  assign bus.data_MR = data_mr_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err_overflow = err_ovf_q;
  assign bus.err_count = err_cnt_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed bench; instance a has defaults, instance b has INST_AW=2 and RD_LAT=3
module tb_program_loader;
  import loader_pkg::*;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;
  program_loader_if #(.INST_W(32), .DATA_W(16), .INST_AW(7), .DATA_AW(11), .ERR_W(8)) ifa ();
  program_loader_if #(.INST_W(32), .DATA_W(16), .INST_AW(2), .DATA_AW(11), .ERR_W(8)) ifb ();
  program_loader #(.RD_LAT(1), .SETTLE_CYC(4)) u_a (.clk(clk), .rst(rst_a), .bus(ifa));
  program_loader #(.INST_AW(2), .RD_LAT(3), .SETTLE_CYC(4)) u_b (.clk(clk), .rst(rst_b), .bus(ifb));
  logic [31:0] imem_a [128];
  logic [15:0] dmem_a [2048];
  logic [31:0] imem_b [4];
  logic [15:0] dmem_b [2048];
  int imw_a = 0, dmw_a = 0, imr_a = 0, dmr_a = 0;
  int imw_b = 0, dmw_b = 0, imr_b = 0, dmr_b = 0;
  // registered-read memory models; data address 1 reads back with bit 0 flipped
  always @(posedge clk) begin
    if (ifa.inst_MW) begin imem_a[ifa.inst_addr] <= ifa.inst_wdata; imw_a <= imw_a + 1; end
    if (ifa.data_MW) begin dmem_a[ifa.data_addr] <= ifa.data_wdata; dmw_a <= dmw_a + 1; end
    if (ifa.inst_MR) imr_a <= imr_a + 1;
    if (ifa.data_MR) dmr_a <= dmr_a + 1;
    ifa.inst_rdata <= imem_a[ifa.inst_addr];
    ifa.data_rdata <= dmem_a[ifa.data_addr] ^ {15'd0, ifa.data_addr == 11'd1};
    if (ifb.inst_MW) begin imem_b[ifb.inst_addr] <= ifb.inst_wdata; imw_b <= imw_b + 1; end
    if (ifb.data_MW) begin dmem_b[ifb.data_addr] <= ifb.data_wdata; dmw_b <= dmw_b + 1; end
    if (ifb.inst_MR) imr_b <= imr_b + 1;
    if (ifb.data_MR) dmr_b <= dmr_b + 1;
    ifb.inst_rdata <= imem_b[ifb.inst_addr];
    ifb.data_rdata <= dmem_b[ifb.data_addr] ^ {15'd0, ifb.data_addr == 11'd1};
  end
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pulse_start(input bit b, input logic v);
    if (b) begin ifb.start = 1'b1; ifb.verify_en = v; end
    else begin ifa.start = 1'b1; ifa.verify_en = v; end
    @(negedge clk);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask
  task automatic send(input bit b, input logic t, input logic [31:0] d, input logic last);
    int n = 0;
    if (b) begin ifb.in_valid = 1'b1; ifb.in_target = t; ifb.in_data = d; ifb.in_last = last; end
    else begin ifa.in_valid = 1'b1; ifa.in_target = t; ifa.in_data = d; ifa.in_last = last; end
    while (!(b ? ifb.in_ready : ifa.in_ready) && n < 40) begin @(negedge clk); n++; end
    chk("handshake", n < 40, 1'b1);
    @(negedge clk);
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
  endtask
  task automatic wait_done(input bit b);
    int n = 0;
    while (!(b ? ifb.done : ifa.done) && n < 200) begin @(negedge clk); n++; end
    chk("done_reached", b ? ifb.done : ifa.done, 1'b1);
  endtask
  initial begin
    int n, i0, d0, ir0, dr0;
    {ifa.start, ifa.verify_en, ifa.in_valid, ifa.in_target, ifa.in_last} = '0;
    {ifb.start, ifb.verify_en, ifb.in_valid, ifb.in_target, ifb.in_last} = '0;
    ifa.in_data = '0;
    ifb.in_data = '0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_rst", ifa.cpu_rst, 1'b1);
    chk("rst_enpc", ifa.cpu_enPC, 1'b0);
    chk("rst_in_ready", ifa.in_ready, 1'b0);
    chk("rst_busy_done", {ifa.busy, ifa.done, ifa.err_overflow}, 3'b000);
    chk("rst_strobes", {ifa.inst_MW, ifa.inst_MR, ifa.data_MW, ifa.data_MR}, 4'b0000);
    chk("rst_addr", {ifa.inst_addr, ifa.data_addr, ifa.err_count}, '0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    chk("idle_no_ready", ifa.in_ready, 1'b0);
    // session 1: three instruction words, no verify
    pulse_start(1'b0, 1'b0);
    chk("t1_busy", {ifa.busy, ifa.in_ready, ifa.cpu_rst}, 3'b111);
    i0 = imw_a; d0 = dmw_a;
    send(1'b0, TGT_INST, 32'h0000_0000, 1'b0);
    send(1'b0, TGT_INST, 32'h8C08_0002, 1'b0);
    send(1'b0, TGT_INST, 32'hAC08_0001, 1'b1);
    n = 0;
    while (ifa.cpu_rst && n < 20) begin @(negedge clk); n++; end
    chk("t1_rst_fall", ifa.cpu_rst, 1'b0);
    chk("t1_imw_cnt", imw_a - i0, 3);
    n = 0;
    while (!ifa.cpu_enPC && n < 20) begin @(negedge clk); n++; end
    chk("t1_settle_cycles", n, 4);
    chk("t1_run", {ifa.done, ifa.busy}, 2'b10);
    chk("t1_mem0", imem_a[0], 32'h0000_0000);
    chk("t1_mem1", imem_a[1], 32'h8C08_0002);
    chk("t1_mem2", imem_a[2], 32'hAC08_0001);
    chk("t1_no_dmw", dmw_a - d0, 0);
    // session 2: mixed stream with a 10-cycle host stall and an ignored start
    pulse_start(1'b0, 1'b0);
    chk("t2_restart", {ifa.cpu_enPC, ifa.cpu_rst, ifa.done}, 3'b010);
    i0 = imw_a; d0 = dmw_a; ir0 = imr_a; dr0 = dmr_a;
    send(1'b0, TGT_DATA, 32'hFFFF_1111, 1'b0);
    send(1'b0, TGT_DATA, 32'hFFFF_2222, 1'b0);
    @(negedge clk);
    n = imw_a + dmw_a;
    repeat (4) @(negedge clk);
    pulse_start(1'b0, 1'b1);
    repeat (5) @(negedge clk);
    chk("t5_no_strobes", imw_a + dmw_a, n);
    chk("t5_in_ready", ifa.in_ready, 1'b1);
    chk("t5_state", u_a.state_q, ACCEPT);
    send(1'b0, TGT_DATA, 32'hFFFF_3333, 1'b0);
    send(1'b0, TGT_INST, 32'h8C08_0002, 1'b1);
    wait_done(1'b0);
    chk("t2_dmem0", dmem_a[0], 16'h1111);
    chk("t2_dmem1", dmem_a[1], 16'h2222);
    chk("t2_dmem2", dmem_a[2], 16'h3333);
    chk("t2_imem0", imem_a[0], 32'h8C08_0002);
    chk("t2_counts", {imw_a - i0, dmw_a - d0}, {32'd1, 32'd3});
    chk("t2_no_reads", {imr_a - ir0, dmr_a - dr0}, 64'd0);
    chk("t2_err", ifa.err_count, 8'd0);
    // session 3a: verify with RD_LAT=1, data address 1 corrupted on readback
    pulse_start(1'b0, 1'b1);
    ir0 = imr_a; dr0 = dmr_a;
    send(1'b0, TGT_DATA, 32'h0000_AAAA, 1'b0);
    send(1'b0, TGT_DATA, 32'h0000_BBBB, 1'b0);
    send(1'b0, TGT_INST, 32'h1122_3344, 1'b1);
    wait_done(1'b0);
    chk("t3a_err", ifa.err_count, 8'd1);
    chk("t3a_reads", {imr_a - ir0, dmr_a - dr0}, {32'd1, 32'd2});
    chk("t3a_imem0", imem_a[0], 32'h1122_3344);
    // session 3b: verify with RD_LAT=3; upper bits of data words are not compared
    pulse_start(1'b1, 1'b1);
    dr0 = dmr_b;
    send(1'b1, TGT_DATA, 32'hFFFF_5555, 1'b0);
    send(1'b1, TGT_DATA, 32'h0000_6666, 1'b0);
    send(1'b1, TGT_DATA, 32'h0000_7777, 1'b1);
    wait_done(1'b1);
    chk("t3b_err", ifb.err_count, 8'd1);
    chk("t3b_reads", dmr_b - dr0, 9);
    chk("t3b_dmem2", dmem_b[2], 16'h7777);
    // session 4: five words into a four-entry instruction memory
    pulse_start(1'b1, 1'b0);
    i0 = imw_b;
    for (int k = 0; k < 5; k++) send(1'b1, TGT_INST, 32'h10 + k, k == 4);
    wait_done(1'b1);
    chk("t4_imw_cnt", imw_b - i0, 4);
    chk("t4_overflow", ifb.err_overflow, 1'b1);
    chk("t4_imem0", imem_b[0], 32'h10);
    chk("t4_imem3", imem_b[3], 32'h13);
    chk("t4_err_cleared", ifb.err_count, 8'd0);
    // session 6: reset during the second WRITE
    pulse_start(1'b0, 1'b0);
    send(1'b0, TGT_INST, 32'hA0, 1'b0);
    send(1'b0, TGT_INST, 32'hB0, 1'b0);
    chk("t6_in_write", ifa.inst_MW, 1'b1);
    rst_a = 1'b0;
    #1;
    chk("t6_async_rst", {ifa.cpu_rst, ifa.cpu_enPC, ifa.busy, ifa.inst_MW}, 4'b1000);
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    pulse_start(1'b0, 1'b0);
    send(1'b0, TGT_INST, 32'hC0, 1'b1);
    wait_done(1'b0);
    chk("t6_imem0", imem_a[0], 32'hC0);
    chk("t6_imem1", imem_a[1], 32'h8C08_0002);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Hardware successor to the manual upload sequence used when bringing up the pipelined MIPS CPU.
- Accepts a valid/ready word stream from a host and writes each word into the CPU instruction memory or data memory through the export ports, holding the CPU in reset while it does so.
- Optionally reads back each word to check it, then releases CPU reset, waits a settle interval and asserts enPC.
- Sits between the host/boot source and MIPS_CPU_Pipelined.

Parameters:
- INST_W, 32, instruction word width
- DATA_W, 16, data word width (must be <= INST_W)
- INST_AW, 7, instruction memory address width
- DATA_AW, 11, data memory address width
- RD_LAT, 1, export read latency in cycles (1..4)
- SETTLE_CYC, 4, cycles between CPU reset release and enPC assertion (>=1)
- ERR_W, 8, error counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load session
- verify_en  in  1  sampled at start; enables per-word readback check
- in_valid  in  1  host word valid
- in_ready  out  1  loader can accept a word
- in_target  in  1  0 = instruction memory, 1 = data memory
- in_data  in  INST_W  word; data-memory writes use bits [DATA_W-1:0]
- in_last  in  1  marks the final word of the session
- cpu_rst  out  1  active-high reset to the CPU
- cpu_enPC  out  1  CPU PC enable
- inst_addr  out  INST_AW  instruction memory export address
- inst_wdata  out  INST_W  instruction memory export write data
- inst_MW, inst_MR  out  1 each  instruction memory export write/read strobes
- inst_rdata  in  INST_W  instruction memory export read data
- data_addr  out  DATA_AW  data memory export address
- data_wdata  out  DATA_W  data memory export write data
- data_MW, data_MR  out  1 each  data memory export write/read strobes
- data_rdata  in  DATA_W  data memory export read data
- busy  out  1  session in progress
- done  out  1  CPU running; held until next start
- err_overflow  out  1  sticky; a word addressed beyond memory depth
- err_count  out  ERR_W  readback mismatches, saturating

Behaviour:
- Reset (rst=0, asynchronous): state IDLE.
  - cpu_rst=1, cpu_enPC=0, in_ready=0, all strobes 0.
  - Addresses, wdata, err_count and both address counters cleared.
  - busy=0, done=0, err_overflow=0.
- States: IDLE, ACCEPT, WRITE, READ, CHECK, SETTLE, RUN.
- IDLE:
  - On start: clear counters, errors and done; latch verify_en; set cpu_rst=1, cpu_enPC=0.
  - Go to ACCEPT; busy=1 from the next cycle.
- ACCEPT: in_ready=1. A word is accepted on in_valid && in_ready.
  - Latch target, word and last; drive addr/wdata from that target's counter.
  - Go to WRITE.
  - in_ready is 0 in every other state.
- WRITE (1 cycle): assert MW of the selected target only.
  - If the address counter has already wrapped, suppress MW and set err_overflow.
  - Increment the counter.
  - Next state: READ if verify_en, else ACCEPT (or SETTLE if last).
- READ: assert MR for RD_LAT cycles at the same address, then go to CHECK.
- CHECK (1 cycle):
  - Compare the rdata of the selected target against the latched word (DATA_W lsbs for data).
  - On mismatch, err_count increments, saturating at all-ones.
  - Next state: ACCEPT, or SETTLE if last.
- Overflowed words skip readback (WRITE goes directly onward).
- SETTLE: cpu_rst=0. Count SETTLE_CYC cycles, then go to RUN.
- RUN: cpu_enPC=1, done=1, busy=0.
  - A start pulse re-enters a session: cpu_enPC drops and cpu_rst rises on the next edge.
- start in any non-IDLE, non-RUN state is ignored.
- in_last on the first word is legal (single-word image).
- Address counters are independent per target.
  - Counter width is AW+1; the top bit flags overflow.
  - Overflowed words are accepted and dropped so the host never stalls.
- Reset mid-session aborts immediately. Memory contents already written are left as-is.
- Throughput: 2 cycles/word without verify; RD_LAT+3 cycles/word with verify.

Decomposition:
- Shared package loader_pkg holds:
  - state enum (IDLE..RUN)
  - target constants TGT_INST=0, TGT_DATA=1
  - default width constants
- One sub-module: loader_addr_ctr, a parametrised (AW+1)-bit counter with clear, increment and overflow output, instantiated once per target.

Test Plan:
1. Reset then start, no verify. Stream inst 0x00000000, 0x8C080002, 0xAC080001 (last) to target 0. Required:
   - inst_MW pulses at addresses 0, 1, 2 with those words.
   - cpu_rst falls after the last write.
   - cpu_enPC rises exactly SETTLE_CYC cycles later; done=1.
2. Mixed stream: data 0, 0, 1 then inst 0x8C080002 (last). Required:
   - data writes at addresses 0..2 with data_wdata = in_data[15:0].
   - inst write at address 0.
   - No cross-target strobes.
3. Verify on, with a memory model that corrupts data address 1. Required: err_count=1 at done and all other words match; check with RD_LAT=1 and RD_LAT=3.
4. INST_AW=2, push 5 instruction words. Required:
   - Exactly 4 inst_MW pulses.
   - err_overflow=1 and the 5th word is accepted (in_ready handshake completes).
   - Session still reaches RUN.
5. Hold in_valid low for 10 cycles mid-stream. Required: no strobes issued and state stays ACCEPT with in_ready=1.
6. Assert rst low during the 2nd WRITE. Required:
   - Outputs return to reset values asynchronously: cpu_rst=1, cpu_enPC=0, busy=0.
   - A fresh start restarts the counters at address 0.
